// File: rtl/peak_frame_ctrl_if.sv
// FFT stream in, peak detector sink out, peak detector results back in.
// slave: the sequencer; master: the FFT/detector environment.
interface peak_frame_ctrl_if;
    logic fft_sop;
    logic fft_eop;
    logic fft_valid;
    logic pd_sink_sop;
    logic pd_sink_eop;
    logic pd_sink_valid;
    logic pd_source_valid;
    logic pd_source_sop;
    logic pd_source_eop;

    modport slave (
        input  fft_sop, fft_eop, fft_valid,
        input  pd_source_valid, pd_source_sop, pd_source_eop,
        output pd_sink_sop, pd_sink_eop, pd_sink_valid
    );

    modport master (
        output fft_sop, fft_eop, fft_valid,
        output pd_source_valid, pd_source_sop, pd_source_eop,
        input  pd_sink_sop, pd_sink_eop, pd_sink_valid
    );
endinterface

// File: rtl/peak_frame_ctrl.sv
// Batch sequencer between FFT output and peak detector.
// Optional DRAIN watchdog: define PEAK_FRAME_CTRL_TIMEOUT_EN.
module peak_frame_ctrl #(
    parameter int BATCH_SIZE     = 1024,
    parameter int NPEAKS         = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    peak_frame_ctrl_if.slave     bus,
    output logic                 pd_reset,
    output logic                 frame_done,
    output logic                 busy,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    localparam int EW = $clog2(BATCH_SIZE);
    localparam int RW = $clog2(NPEAKS + 1);
    localparam logic [EW-1:0] ELAST = EW'(BATCH_SIZE - 1);
    localparam logic [RW-1:0] RLAST = RW'(NPEAKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t        st, st_n;
    logic [EW-1:0] ecnt, ecnt_n;
    logic [RW-1:0] rcnt, rcnt_n;
    logic          inc_frame, inc_drop, inc_err;
    logic          fwd, fwd_sop, fwd_eop;
    logic          sop_beat, last, res_bad;

`ifdef PEAK_FRAME_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt;
`endif

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    assign sop_beat = bus.fft_valid && bus.fft_sop;
    assign last     = (ecnt == ELAST);
    assign res_bad  = (bus.pd_source_sop != (rcnt == '0)) ||
                      (bus.pd_source_eop != (rcnt == RLAST));

    always_comb begin
        st_n      = st;
        ecnt_n    = ecnt;
        rcnt_n    = rcnt;
        inc_frame = 1'b0;
        inc_drop  = 1'b0;
        inc_err   = 1'b0;
        fwd       = 1'b0;
        fwd_sop   = 1'b0;
        fwd_eop   = 1'b0;
        unique case (st)
            IDLE: begin
                if (sop_beat) begin
                    if (enable) begin
                        fwd     = 1'b1;
                        fwd_sop = 1'b1;
                        ecnt_n  = EW'(1);
                        st_n    = LOAD;
                    end else begin
                        inc_drop = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.fft_valid) begin
                    if (!bus.fft_sop && !last && !bus.fft_eop) begin
                        fwd    = 1'b1;
                        ecnt_n = ecnt + 1'b1;
                    end else if (!bus.fft_sop && last && bus.fft_eop) begin
                        fwd     = 1'b1;
                        fwd_eop = 1'b1;
                        rcnt_n  = '0;
                        st_n    = DRAIN;
                    end else begin
                        inc_err = 1'b1;
                        st_n    = FLUSH;
                    end
                end
            end
            DRAIN: begin
                inc_drop = sop_beat;
                if (bus.pd_source_valid) begin
                    if (res_bad) begin
                        inc_err = 1'b1;
                        st_n    = FLUSH;
                    end else if (rcnt == RLAST) begin
                        inc_frame = 1'b1;
                        st_n      = IDLE;
                    end else begin
                        rcnt_n = rcnt + 1'b1;
                    end
                end
`ifdef PEAK_FRAME_CTRL_TIMEOUT_EN
                else if (tcnt == TLAST) begin
                    inc_err = 1'b1;
                    st_n    = FLUSH;
                end
`endif
            end
            FLUSH: begin
                inc_drop = sop_beat;
                st_n     = IDLE;
            end
        endcase
    end

    // Zero-latency gating; the FFT data bus itself bypasses this block.
    assign bus.pd_sink_valid = fwd & ~reset;
    assign bus.pd_sink_sop   = fwd_sop & ~reset;
    assign bus.pd_sink_eop   = fwd_eop & ~reset;
    assign state             = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            ecnt       <= '0;
            rcnt       <= '0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
            err_cnt    <= '0;
            pd_reset   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            st         <= st_n;
            ecnt       <= ecnt_n;
            rcnt       <= rcnt_n;
            pd_reset   <= (st_n == FLUSH);
            frame_done <= inc_frame;
            busy       <= (st_n != IDLE);
            if (inc_frame) frame_cnt <= sat_inc(frame_cnt);
            if (inc_drop)  drop_cnt  <= sat_inc(drop_cnt);
            if (inc_err)   err_cnt   <= sat_inc(err_cnt);
        end
    end

`ifdef PEAK_FRAME_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (st != DRAIN) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_peak_frame_ctrl.sv
// Randomized scenario bench for peak_frame_ctrl (BATCH_SIZE=8, NPEAKS=4).
// Expected counts come from per-scenario outcome rules.
module tb_peak_frame_ctrl;

    localparam int BS = 8;
    localparam int NP = 4;
    localparam int TO = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          pd_reset, frame_done, busy;
    logic [1:0]    state;
    logic [CW-1:0] frame_cnt, drop_cnt, err_cnt;

    peak_frame_ctrl_if bus();

    peak_frame_ctrl #(
        .BATCH_SIZE(BS),
        .NPEAKS(NP),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .bus(bus),
        .pd_reset(pd_reset),
        .frame_done(frame_done),
        .busy(busy),
        .state(state),
        .frame_cnt(frame_cnt),
        .drop_cnt(drop_cnt),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_fwd, n_sop, n_eop, n_stray, n_prst, n_done;
    int m_frame, m_drop, m_err;
    int e_fwd, e_sop, e_eop, e_prst, e_done;

    always @(negedge clk) begin
        if (bus.pd_sink_valid) begin
            n_fwd++;
            if (bus.pd_sink_sop) n_sop++;
            if (bus.pd_sink_eop) n_eop++;
        end else if (bus.pd_sink_sop || bus.pd_sink_eop) begin
            n_stray++;
        end
        if (pd_reset)   n_prst++;
        if (frame_done) n_done++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_fwd = 0; n_sop = 0; n_eop = 0;
        n_stray = 0; n_prst = 0; n_done = 0;
    endtask

    task automatic cyc(input bit fv, input bit fs, input bit fe,
                       input bit rv, input bit rs, input bit re);
        bus.fft_valid       = fv;
        bus.fft_sop         = fs;
        bus.fft_eop         = fe;
        bus.pd_source_valid = rv;
        bus.pd_source_sop   = rs;
        bus.pd_source_eop   = re;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic gap();
        idle($urandom_range(0, 2));
    endtask

    // bad: 0 clean, 1 early eop at pos, 2 sop at pos, 3 missing eop
    task automatic load_batch(input int bad, input int pos, input bit tog);
        bit s, e;
        for (int b = 0; b < BS; b++) begin
            s = (b == 0);
            e = (b == BS - 1);
            if (b > 0) begin
                gap();
                if (tog) enable = 1'($urandom_range(0, 1));
            end
            if (bad == 1 && b == pos) e = 1'b1;
            if (bad == 2 && b == pos) s = 1'b1;
            if (bad == 3 && b == BS - 1) e = 1'b0;
            cyc(1, s, e, 0, 0, 0);
            if (bad != 0 && b == pos) break;
        end
    endtask

    task automatic drain(input int bad_j, input bit flip_sop);
        bit rs, re;
        for (int j = 0; j < NP; j++) begin
            gap();
            rs = (j == 0);
            re = (j == NP - 1);
            if (j == bad_j) begin
                if (flip_sop) rs = ~rs;
                else          re = ~re;
            end
            cyc(0, 0, 0, 1, rs, re);
            if (j == bad_j) break;
        end
    endtask

    task automatic set_clean();
        e_fwd = BS; e_sop = 1; e_eop = 1; e_prst = 0; e_done = 1;
    endtask

    task automatic run(input int kind);
        int sub, pos, r0, d, len;
        bit fv, fs, fe, rv, rs, re;
        clr();
        enable = 1'b1;
        case (kind)
            0: begin
                load_batch(0, 0, 0);
                chk("drain_state", int'(state), 2);
                chk("drain_busy", int'(busy), 1);
                drain(-1, 0);
                set_clean();
                m_frame++;
            end
            1: begin
                load_batch(0, 0, 0);
                idle(2);
                r0  = $urandom_range(0, 3);
                d   = $urandom_range(0, r0 + NP - 1);
                len = (r0 + NP > d + BS) ? r0 + NP : d + BS;
                for (int c = 0; c < len; c++) begin
                    fv = (c >= d) && (c < d + BS);
                    fs = (c == d);
                    fe = (c == d + BS - 1);
                    rv = (c >= r0) && (c < r0 + NP);
                    rs = (c == r0);
                    re = (c == r0 + NP - 1);
                    cyc(fv, fs, fe, rv, rs, re);
                end
                set_clean();
                m_frame++;
                m_drop++;
            end
            2: begin
                sub = $urandom_range(1, 3);
                if (sub == 1)      pos = $urandom_range(1, BS - 2);
                else if (sub == 2) pos = $urandom_range(1, BS - 1);
                else               pos = BS - 1;
                load_batch(sub, pos, 0);
                chk("err_flush_state", int'(state), 3);
                chk("err_flush_pulse", int'(pd_reset), 1);
                e_fwd = pos; e_sop = 1; e_eop = 0; e_prst = 1; e_done = 0;
                m_err++;
            end
            3: begin
                load_batch(0, 0, 0);
                drain($urandom_range(0, NP - 1), 1'($urandom_range(0, 1)));
                chk("res_err_state", int'(state), 3);
                e_fwd = BS; e_sop = 1; e_eop = 1; e_prst = 1; e_done = 0;
                m_err++;
            end
            4: begin
                enable = 1'b0;
                cyc(1, 1, 0, 0, 0, 0);
                enable = 1'b1;
                for (int b = 1; b < BS; b++) begin
                    gap();
                    cyc(1, 0, b == BS - 1, 0, 0, 0);
                end
                e_fwd = 0; e_sop = 0; e_eop = 0; e_prst = 0; e_done = 0;
                m_drop++;
            end
            default: begin
                cyc(0, 0, 0, 1, 1, 0);
                load_batch(0, 0, 1);
                enable = 1'b1;
                drain(-1, 0);
                set_clean();
                m_frame++;
            end
        endcase
        enable = 1'b1;
        idle(2);
        chk("end_state", int'(state), 0);
        chk("end_busy", int'(busy), 0);
        chk("frame_cnt", int'(frame_cnt), m_frame);
        chk("drop_cnt", int'(drop_cnt), m_drop);
        chk("err_cnt", int'(err_cnt), m_err);
        chk("sink_beats", n_fwd, e_fwd);
        chk("sink_sop", n_sop, e_sop);
        chk("sink_eop", n_eop, e_eop);
        chk("sink_stray", n_stray, 0);
        chk("pd_reset_cycles", n_prst, e_prst);
        chk("frame_done_cycles", n_done, e_done);
    endtask

    initial begin
        int kind;
        m_frame = 0; m_drop = 0; m_err = 0;
        clr();
        bus.fft_valid = 0; bus.fft_sop = 0; bus.fft_eop = 0;
        bus.pd_source_valid = 0;
        bus.pd_source_sop = 0;
        bus.pd_source_eop = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pd_reset", int'(pd_reset), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        reset = 1'b0;
        idle(1);

        for (int i = 0; i < 36; i++) begin
            kind = (i < 6) ? i : int'($urandom_range(0, 5));
            run(kind);
        end

        clr();
        enable = 1'b1;
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        bus.fft_valid = 1'b1;
        bus.fft_sop   = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_frame_cnt", int'(frame_cnt), 0);
        chk("arst_drop_cnt", int'(drop_cnt), 0);
        chk("arst_err_cnt", int'(err_cnt), 0);
        chk("arst_sink_valid", int'(bus.pd_sink_valid), 0);
        @(posedge clk);
        #1;
        bus.fft_valid = 1'b0;
        bus.fft_sop   = 1'b0;
        reset = 1'b0;
        m_frame = 0; m_drop = 0; m_err = 0;
        idle(1);
        run(0);

`ifdef PEAK_FRAME_CTRL_TIMEOUT_EN
        clr();
        load_batch(0, 0, 0);
        idle(TO - 1);
        chk("to_pre_state", int'(state), 2);
        chk("to_pre_err", int'(err_cnt), m_err);
        idle(1);
        m_err++;
        chk("to_state", int'(state), 3);
        chk("to_err", int'(err_cnt), m_err);
        idle(2);
        chk("to_idle", int'(state), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/peak_frame_ctrl.md
Name: peak_frame_ctrl

Overview:
- Batch sequencer placed between the FFT output stream and the peak detector.
- Admits one complete FFT batch at a time into the detector and blocks further input until that batch's NPEAKS results have drained.
- Drops batches that arrive while the detector is busy, detects malformed framing and flushes the detector on error.
- Keeps frame, drop and error statistics for the host.

Parameters:
- BATCH_SIZE, 1024, entries per FFT batch; must be >= 2.
- NPEAKS, 4, result beats the peak detector emits per batch.
- TIMEOUT_CYCLES, 4096, maximum DRAIN duration (used only with the optional feature).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  high: new batches may be admitted.
- fft_sop  in  1  first entry of FFT batch.
- fft_eop  in  1  last entry of FFT batch.
- fft_valid  in  1  FFT entry valid.
- pd_sink_sop  out  1  gated sop to peak detector.
- pd_sink_eop  out  1  gated eop to peak detector.
- pd_sink_valid  out  1  gated valid to peak detector.
- pd_reset  out  1  one-cycle flush pulse to peak detector.
- pd_source_valid  in  1  peak detector result valid.
- pd_source_sop  in  1  first result beat.
- pd_source_eop  in  1  last result beat.
- frame_done  out  1  one-cycle pulse when a batch completes.
- busy  out  1  state != IDLE.
- state  out  2  IDLE=0, LOAD=1, DRAIN=2, FLUSH=3.
- frame_cnt  out  CNT_WIDTH  completed batches.
- drop_cnt  out  CNT_WIDTH  batches dropped while busy or disabled.
- err_cnt  out  CNT_WIDTH  framing and protocol errors.

Behaviour:
- Reset (asynchronous): state=IDLE; all counters 0; pd_reset=0; frame_done=0; busy=0. pd_sink_* are 0 while reset is high.
- Timing:
  - pd_sink_* are combinational from fft_* and the registered state, so there is zero latency. The FFT data bus routes directly to the detector.
  - All other outputs are registered.
- Entry counter ecnt is $clog2(BATCH_SIZE) bits. Result counter rcnt is $clog2(NPEAKS+1) bits.
- Statistics counters saturate at all-ones and never wrap.
- IDLE:
  - fft_valid&&fft_sop&&enable: forward the beat (pd_sink_valid=1, pd_sink_sop=1), set ecnt=1, go to LOAD.
  - fft_valid&&fft_sop&&!enable: drop_cnt+1, nothing forwarded.
  - fft_valid without sop: discarded silently.
- LOAD (checks apply to each fft_valid beat):
  - Beat with ecnt<BATCH_SIZE-1, no sop, no eop: forward it, ecnt+1.
  - Beat with ecnt==BATCH_SIZE-1 and eop: forward it with pd_sink_eop=1, clear rcnt, go to DRAIN.
  - Any of the following is an error: sop on the beat; eop with ecnt<BATCH_SIZE-1; missing eop at ecnt==BATCH_SIZE-1. On error: beat not forwarded, err_cnt+1, go to FLUSH.
  - Cycles without fft_valid are holes; ecnt holds.
  - Deasserting enable mid-batch does not abort the batch.
- DRAIN:
  - pd_sink_* held 0.
  - Each fft_valid&&fft_sop: drop_cnt+1. Its batch is not forwarded, including later beats after returning to IDLE without a sop.
  - Each pd_source_valid: rcnt+1. The beat is checked for sop==(rcnt==0) and eop==(rcnt==NPEAKS-1). On a mismatch: err_cnt+1, go to FLUSH.
  - On the beat with rcnt==NPEAKS-1 (valid): frame_cnt+1, frame_done=1 for one cycle, go to IDLE.
- Simultaneous events:
  - Final result beat and a new fft sop in the same cycle: the sop counts as a drop, because the state is still DRAIN.
  - pd_source_valid outside DRAIN is ignored.
- FLUSH:
  - pd_reset=1 for exactly one cycle; pd_sink_* held 0.
  - Next state is IDLE. An fft sop during FLUSH counts as a drop.
- Reset mid-operation returns immediately to IDLE with cleared statistics. No pd_reset pulse is generated; the detector shares the system reset.

Optional Feature:
- Macro: PEAK_FRAME_CTRL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in DRAIN, cleared on DRAIN entry.
  - If TIMEOUT_CYCLES cycles elapse without the final result: err_cnt+1, go to FLUSH.
- Undefined: DRAIN waits indefinitely and TIMEOUT_CYCLES is unused.

Test Plan:
Test settings: BATCH_SIZE=8, NPEAKS=4.
- Clean frame: 8-beat batch with sop on beat 0 and eop on beat 7, then 4 result beats with correct sop/eop -> pd_sink_valid on all 8 beats, pd_sink_eop on beat 7; frame_done pulses once; frame_cnt=1; drop_cnt=0; err_cnt=0.
- Busy drop: second batch starts 2 cycles after the first batch's eop, during DRAIN -> none of its beats forwarded; drop_cnt=1. A third batch after completion is accepted; frame_cnt=2.
- Short frame: eop on beat 5 -> beat 5 not forwarded; err_cnt=1; pd_reset high exactly 1 cycle; state returns to IDLE.
- Result protocol error: second result beat carries sop -> err_cnt=1; FLUSH pulse; frame_cnt unchanged.
- Disabled/holes: enable=0 at sop -> drop_cnt+1. enable=1 with fft_valid holes inside a batch -> all 8 beats forwarded; frame completes.
- Async reset asserted mid-LOAD at beat 3 -> immediately state=0, all counters 0, pd_sink_valid=0. A next full batch completes normally. With PEAK_FRAME_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, withholding results gives err_cnt=1 at DRAIN cycle 16.
